db9md_pad_scanner: RTL and testbench

//  Scans up to two Sega Mega Drive 3/6-button pads on the shared DB9 user port (via external splitter).

---
 rtl/db9md_pkg.sv | 57 +++++
 rtl/db9md_decode.sv | 40 ++++
 rtl/db9md_pad_scanner.sv | 161 ++++++++++++++++
 tb/tb_db9md_pad_scanner.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/db9md_pkg.sv
// Shared constants, types and helpers for the Mega Drive DB9 pad scanner.
// Holds joystick bit map, scan phase indices, scan state enum and sample bundle.
package db9md_pkg;

   // Decoded joystick word bit positions (active-high)
   localparam int JB_RIGHT = 0;
   localparam int JB_LEFT  = 1;
   localparam int JB_DOWN  = 2;
   localparam int JB_UP    = 3;
   localparam int JB_B     = 4;
   localparam int JB_C     = 5;
   localparam int JB_A     = 6;
   localparam int JB_START = 7;
   localparam int JB_MODE  = 8;
   localparam int JB_X     = 9;
   localparam int JB_Y     = 10;
   localparam int JB_Z     = 11;

   // Select phases that carry useful data
   localparam logic [2:0] PH_BASIC = 3'd0;
   localparam logic [2:0] PH_ABST  = 3'd1;
   localparam logic [2:0] PH_ID    = 3'd5;
   localparam logic [2:0] PH_EXT   = 3'd6;
   localparam logic [2:0] PH_LAST  = 3'd7;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } scan_state_e;

   // Raw active-low bus captures for one port
   typedef struct packed {
      logic [5:0] basic;
      logic [5:0] abst;
      logic [5:0] id;
      logic [5:0] ext;
   } pad_smp_t;

   // Store a bus capture into the slot owned by phase p
   function automatic pad_smp_t smp_store(
      input pad_smp_t   s,
      input logic [2:0] p,
      input logic [5:0] v
   );
      pad_smp_t r;
      r = s;
      case (p)
         PH_BASIC: r.basic = v;
         PH_ABST:  r.abst  = v;
         PH_ID:    r.id    = v;
         PH_EXT:   r.ext   = v;
         default:  r       = s;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/db9md_decode.sv
// Per-port decoder: raw phase captures -> ungated 16-bit word + present/six flags.
// Ports: p0/p1/p5/p6 raw active-low bus captures; word, present, six outputs.
module db9md_decode
   import db9md_pkg::*;
(
   input  logic [5:0]  p0,
   input  logic [5:0]  p1,
   input  logic [5:0]  p5,
   input  logic [5:0]  p6,
   output logic [15:0] word,
   output logic        present,
   output logic        six
);

   // Bus: {pin9,pin6,pin4,pin3,pin2,pin1}
   always_comb begin
      word           = '0;
      word[JB_RIGHT] = ~p0[3];
      word[JB_LEFT]  = ~p0[2];
      word[JB_DOWN]  = ~p0[1];
      word[JB_UP]    = ~p0[0];
      word[JB_B]     = ~p0[4];
      word[JB_C]     = ~p0[5];
      word[JB_A]     = ~p1[4];
      word[JB_START] = ~p1[5];
      word[JB_MODE]  = ~p6[0];
      word[JB_Z]     = ~p6[1];
      word[JB_Y]     = ~p6[2];
      word[JB_X]     = ~p6[3];
   end

   // Any MD pad pulls L and R low while select is low
   assign present = ~p1[2] & ~p1[3];
   // Only a 6-button pad grounds all four direction pins in phase 5
   assign six     = (p5[3:0] == 4'b0000);

   logic unused_bits;
   assign unused_bits = ^{p1[1:0], p5[5:4], p6[5:4]};

endmodule

// File: rtl/db9md_pad_scanner.sv
// Scans two Mega Drive pads through a DB9 splitter and publishes decoded words.
// Ports: clk_sys, reset (sync, high), joy_in[5:0] (active-low bus), joy_mdsel,
// joy_split, joystick1/joystick2[15:0]. Option macro: DB9MD_DEBOUNCE_EN.
module db9md_pad_scanner
   import db9md_pkg::*;
#(
   parameter int PHASE_CYCLES = 400,
   parameter int IDLE_CYCLES  = 80000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [5:0]  joy_in,
   output logic        joy_mdsel,
   output logic        joy_split,
   output logic [15:0] joystick1,
   output logic [15:0] joystick2
);

   localparam int CW = $clog2(PHASE_CYCLES);
   localparam int IW = $clog2(IDLE_CYCLES);

   localparam logic [CW-1:0] CYC_HALF  = CW'(PHASE_CYCLES / 2 - 1);
   localparam logic [CW-1:0] CYC_LAST  = CW'(PHASE_CYCLES - 1);
   localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);

   scan_state_e state_q, state_d;
   logic [IW-1:0] idle_q, idle_d;
   logic [2:0]    phase_q, phase_d;
   logic [CW-1:0] cyc_q, cyc_d;

   pad_smp_t [1:0]    smp_q, smp_d;
   logic [1:0][15:0]  word_q, word_d;
`ifdef DB9MD_DEBOUNCE_EN
   logic [1:0][15:0]  prev_q, prev_d;
`endif

   logic [1:0][15:0] raw;
   logic [1:0][15:0] dec;
   logic [1:0]       present;
   logic [1:0]       six;

   db9md_decode u_dec0 (
      .p0      (smp_q[0].basic),
      .p1      (smp_q[0].abst),
      .p5      (smp_q[0].id),
      .p6      (smp_q[0].ext),
      .word    (raw[0]),
      .present (present[0]),
      .six     (six[0])
   );

   db9md_decode u_dec1 (
      .p0      (smp_q[1].basic),
      .p1      (smp_q[1].abst),
      .p5      (smp_q[1].id),
      .p6      (smp_q[1].ext),
      .word    (raw[1]),
      .present (present[1]),
      .six     (six[1])
   );

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         if (!present[i])
            dec[i] = '0;
         else if (six[i])
            dec[i] = raw[i];
         else
            dec[i] = {8'h00, raw[i][7:0]};
      end
   end

   always_comb begin
      logic commit;
      commit  = 1'b0;
      state_d = state_q;
      idle_d  = idle_q;
      phase_d = phase_q;
      cyc_d   = cyc_q;
      smp_d   = smp_q;
      word_d  = word_q;
`ifdef DB9MD_DEBOUNCE_EN
      prev_d  = prev_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (idle_q == '0) begin
               state_d = ST_SCAN;
               phase_d = '0;
               cyc_d   = '0;
            end else begin
               idle_d = idle_q - IW'(1);
            end
         end
         ST_SCAN: begin
            // Port0 is on the bus in the first half, port1 in the second
            if (cyc_q == CYC_HALF)
               smp_d[0] = smp_store(smp_q[0], phase_q, joy_in);
            if (cyc_q == CYC_LAST)
               smp_d[1] = smp_store(smp_q[1], phase_q, joy_in);
            if (cyc_q == CYC_LAST) begin
               cyc_d = '0;
               if (phase_q == PH_LAST) begin
                  state_d = ST_IDLE;
                  idle_d  = IDLE_LAST;
                  commit  = 1'b1;
               end else begin
                  phase_d = phase_q + 3'd1;
               end
            end else begin
               cyc_d = cyc_q + CW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (commit) begin
`ifdef DB9MD_DEBOUNCE_EN
         // Publish only when two consecutive frames decode identically
         for (int i = 0; i < 2; i++) begin
            if (dec[i] == prev_q[i])
               word_d[i] = dec[i];
            prev_d[i] = dec[i];
         end
`else
         word_d = dec;
`endif
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q <= ST_IDLE;
         idle_q  <= IDLE_LAST;
         phase_q <= '0;
         cyc_q   <= '0;
         smp_q   <= '1;
         word_q  <= '0;
`ifdef DB9MD_DEBOUNCE_EN
         prev_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         idle_q  <= idle_d;
         phase_q <= phase_d;
         cyc_q   <= cyc_d;
         smp_q   <= smp_d;
         word_q  <= word_d;
`ifdef DB9MD_DEBOUNCE_EN
         prev_q  <= prev_d;
`endif
      end
   end

   // Select is high in idle and on even phases
   assign joy_mdsel = (state_q == ST_IDLE) | ~phase_q[0];
   assign joy_split = (state_q == ST_SCAN) & (cyc_q > CYC_HALF);
   assign joystick1 = word_q[0];
   assign joystick2 = word_q[1];

endmodule

// File: tb/tb_db9md_pad_scanner.sv
// Self-checking bench for db9md_pad_scanner with behavioural MD pads behind a
// splitter mux; small PHASE/IDLE parameters keep frames at 128 cycles.
module tb_db9md_pad_scanner;

   localparam int PC       = 8;
   localparam int IC       = 64;
   localparam int FRAME    = IC + 8 * PC;
   localparam int PAD_TMO  = 32;
   localparam int PAD_NONE = 0;
   localparam int PAD_3    = 1;
   localparam int PAD_6    = 2;

   logic        clk_sys = 1'b0;
   logic        reset   = 1'b1;
   logic [5:0]  joy_in;
   logic        joy_mdsel;
   logic        joy_split;
   logic [15:0] joystick1;
   logic [15:0] joystick2;

   int n_chk  = 0;
   int n_fail = 0;
   int t      = 0;

   int          pad_type [2];
   logic [11:0] pad_btn  [2];
   int          pad_k    = 0;
   int          pad_idle = 0;
   logic        pad_last = 1'b1;

   logic [15:0] mo [2];
   logic [15:0] mp [2];

   typedef struct {
      int          t0;
      logic [11:0] b0;
      int          t1;
      logic [11:0] b1;
      logic [15:0] e0;
      logic [15:0] e1;
   } vec_t;

   vec_t vecs [7];

   db9md_pad_scanner #(
      .PHASE_CYCLES (PC),
      .IDLE_CYCLES  (IC)
   ) dut (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .joy_in    (joy_in),
      .joy_mdsel (joy_mdsel),
      .joy_split (joy_split),
      .joystick1 (joystick1),
      .joystick2 (joystick2)
   );

   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) t <= reset ? 0 : t + 1;

   // Pad internal counter: select transitions, cleared after a quiet timeout
   always @(negedge clk_sys) begin
      pad_last <= joy_mdsel;
      if (joy_mdsel !== pad_last) begin
         pad_k    <= (pad_k < 15) ? pad_k + 1 : 15;
         pad_idle <= 0;
      end else if (pad_idle >= PAD_TMO) begin
         pad_k <= 0;
      end else begin
         pad_idle <= pad_idle + 1;
      end
   end

   // Button vector b uses the joystick word bit map; result is the
   // active-low bus {pin9,pin6,pin4,pin3,pin2,pin1}
   function automatic logic [5:0] pad_bus(
      input int typ, input logic [11:0] b, input int k, input logic sel
   );
      if (typ == PAD_NONE) return 6'h3F;
      if (typ == PAD_6 && k == 5) return {~b[7], ~b[6], 4'b0000};
      if (typ == PAD_6 && k == 6)
         return {~b[5], ~b[4], ~b[9], ~b[10], ~b[11], ~b[8]};
      if (typ == PAD_6 && k == 7) return {~b[7], ~b[6], 4'b1111};
      if (sel) return {~b[5], ~b[4], ~b[0], ~b[1], ~b[2], ~b[3]};
      return {~b[7], ~b[6], 2'b00, ~b[2], ~b[3]};
   endfunction

   assign joy_in = joy_split
      ? pad_bus(pad_type[1], pad_btn[1], pad_k, joy_mdsel)
      : pad_bus(pad_type[0], pad_btn[0], pad_k, joy_mdsel);

   function automatic logic [15:0] exp_word(input int typ, input logic [11:0] b);
      if (typ == PAD_3) return {8'h00, b[7:0]};
      if (typ == PAD_6) return {4'h0, b};
      return 16'h0000;
   endfunction

   task automatic model_frame();
      logic [15:0] d;
      for (int i = 0; i < 2; i++) begin
         d = exp_word(pad_type[i], pad_btn[i]);
`ifdef DB9MD_DEBOUNCE_EN
         if (d == mp[i]) mo[i] = d;
         mp[i] = d;
`else
         mo[i] = d;
`endif
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic goto_r(input int r);
      int n;
      n = 0;
      while ((t % FRAME) != r) begin
         if (n > 2 * FRAME) begin
            n_chk++;
            n_fail++;
            $display("FAIL goto_r: offset %0d not reached", r);
            return;
         end
         step();
         n++;
      end
   endtask

   task automatic run_frame();
      step();
      goto_r(8);
      model_frame();
   endtask

   task automatic set_pads(input int t0, input logic [11:0] b0,
                           input int t1, input logic [11:0] b1);
      pad_type[0] = t0;
      pad_btn[0]  = b0;
      pad_type[1] = t1;
      pad_btn[1]  = b1;
   endtask

   task automatic measure_fall(input string name);
      int n;
      n = 0;
      while (joy_mdsel === 1'b1 && n < 300) begin
         step();
         n++;
      end
      chk(name, n, IC + PC);
   endtask

   initial begin
      int cnt;
      logic [11:0] b;
      int ty;

      vecs[0] = '{PAD_6,    12'h240, PAD_NONE, 12'h000, 16'h0240, 16'h0000};
      vecs[1] = '{PAD_NONE, 12'h000, PAD_3,    12'h088, 16'h0000, 16'h0088};
      vecs[2] = '{PAD_3,    12'hF88, PAD_3,    12'h08B, 16'h0088, 16'h008B};
      vecs[3] = '{PAD_6,    12'hFFB, PAD_6,    12'h001, 16'h0FFB, 16'h0001};
      vecs[4] = '{PAD_6,    12'h000, PAD_3,    12'h0F0, 16'h0000, 16'h00F0};
      vecs[5] = '{PAD_6,    12'h900, PAD_NONE, 12'h000, 16'h0900, 16'h0000};
      vecs[6] = '{PAD_3,    12'h0F7, PAD_6,    12'h4A0, 16'h00F7, 16'h04A0};

      set_pads(PAD_NONE, 12'h000, PAD_NONE, 12'h000);
      mo = '{16'h0, 16'h0};
      mp = '{16'h0, 16'h0};

      reset = 1'b1;
      repeat (2) @(posedge clk_sys);
      #1;
      reset = 1'b0;
      chk("rst_mdsel", joy_mdsel, 1'b1);
      chk("rst_split", joy_split, 1'b0);
      chk("rst_joy1", joystick1, 16'h0);
      chk("rst_joy2", joystick2, 16'h0);
      measure_fall("first_fall");

      for (int c = 0; c < PC; c++) begin
         chk("p1_split", joy_split, (c >= PC / 2) ? 1'b1 : 1'b0);
         chk("p1_mdsel", joy_mdsel, 1'b0);
         step();
      end

      for (int v = 0; v < 7; v++) begin
         goto_r(8);
         set_pads(vecs[v].t0, vecs[v].b0, vecs[v].t1, vecs[v].b1);
         run_frame();
         run_frame();
         chk($sformatf("vec%0d_joy1", v), joystick1, vecs[v].e0);
         chk($sformatf("vec%0d_joy2", v), joystick2, vecs[v].e1);
      end

      set_pads(PAD_6, 12'h240, PAD_NONE, 12'h000);
      run_frame();
      run_frame();
      set_pads(PAD_NONE, 12'h000, PAD_NONE, 12'h000);
      run_frame();
`ifdef DB9MD_DEBOUNCE_EN
      chk("remove_f1", joystick1, 16'h0240);
`else
      chk("remove_f1", joystick1, 16'h0000);
`endif
      run_frame();
      chk("remove_f2", joystick1, 16'h0000);

      set_pads(PAD_6, 12'h000, PAD_NONE, 12'h000);
      run_frame();
      run_frame();
      pad_btn[0] = 12'h010;
      model_frame();
      cnt = 0;
      for (int i = 0; i < 3 * FRAME; i++) begin
         step();
         if (joystick1[4]) cnt++;
         if (i == FRAME - 1) begin
            pad_btn[0] = 12'h000;
            model_frame();
         end
         if (i == 2 * FRAME - 1) model_frame();
      end
`ifdef DB9MD_DEBOUNCE_EN
      chk("b_pulse_cycles", cnt, 0);
`else
      chk("b_pulse_cycles", cnt, FRAME);
`endif

      for (int f = 0; f < 24; f++) begin
         chk($sformatf("rnd%0d_joy1", f), joystick1, mo[0]);
         chk($sformatf("rnd%0d_joy2", f), joystick2, mo[1]);
         for (int i = 0; i < 2; i++) begin
            if ($urandom_range(0, 1) == 1) begin
               ty = int'($urandom_range(0, 2));
               b  = 12'($urandom);
               if (b[3]) b[2] = 1'b0;
               pad_type[i] = ty;
               pad_btn[i]  = b;
            end
         end
         run_frame();
      end

      set_pads(PAD_6, 12'hFFF, PAD_6, 12'hFFF);
      run_frame();
      run_frame();
      goto_r(IC + 4 * PC + 3);
      chk("pre_rst_joy1", joystick1, 16'h0FFF);
      chk("pre_rst_joy2", joystick2, 16'h0FFF);
      reset = 1'b1;
      step();
      chk("mid_rst_mdsel", joy_mdsel, 1'b1);
      chk("mid_rst_split", joy_split, 1'b0);
      chk("mid_rst_joy1", joystick1, 16'h0);
      chk("mid_rst_joy2", joystick2, 16'h0);
      reset = 1'b0;
      measure_fall("mid_rst_fall");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
